// File: rtl/ps2_scancode_decoder.sv
// PS/2 scan-code decoder: synchronizes receiver frames, checks parity, strips
// E0/F0 prefixes and tracks held state of the left/right/space game keys.
module ps2_scancode_decoder #(
    parameter int unsigned TIMEOUT = 100000
) (
    input  logic       CLK,
    input  logic       Resetn,
    input  logic       RxReady,
    input  logic [7:0] RxData,
    input  logic       RxParity,
    output logic       KeyValid,
    output logic [7:0] KeyCode,
    output logic       KeyExtended,
    output logic       KeyRelease,
    output logic       LeftHeld,
    output logic       RightHeld,
    output logic       FireHeld,
    output logic       ParityErr
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [7:0] CODE_EXT   = 8'hE0;
    localparam logic [7:0] CODE_BRK   = 8'hF0;
    localparam logic [7:0] CODE_LEFT  = 8'h6B;
    localparam logic [7:0] CODE_RIGHT = 8'h74;
    localparam logic [7:0] CODE_FIRE  = 8'h29;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nx_c;
    logic             s1, s2, s3;
    logic [CNT_W-1:0] cnt;
    logic             stb_c;
    logic             par_ok_c;
    logic             is_ext_c;
    logic             is_brk_c;
    logic             is_ign_c;
    logic             emit_c;
    logic             emit_ext_c;
    logic             emit_rel_c;

    // Byte classification and prefix state machine decode for a good strobe.
    always_comb begin
        stb_c      = s2 & ~s3;
        par_ok_c   = ^{RxData, RxParity};
        is_ext_c   = (RxData == CODE_EXT);
        is_brk_c   = (RxData == CODE_BRK);
        is_ign_c   = 1'b0;
        state_nx_c = IDLE;
        emit_c     = 1'b0;
        emit_ext_c = 1'b0;
        emit_rel_c = 1'b0;

        case (RxData)
            8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFF: is_ign_c = 1'b1;
            default:                                  is_ign_c = 1'b0;
        endcase

        if (!is_ign_c) begin
            unique case (state)
                IDLE: begin
                    if (is_ext_c)      state_nx_c = EXT;
                    else if (is_brk_c) state_nx_c = BRK;
                    else               emit_c     = 1'b1;
                end
                EXT: begin
                    if (is_ext_c)      state_nx_c = EXT;
                    else if (is_brk_c) state_nx_c = EXT_BRK;
                    else begin
                        emit_c     = 1'b1;
                        emit_ext_c = 1'b1;
                    end
                end
                BRK: begin
                    if (is_brk_c)      state_nx_c = BRK;
                    else if (is_ext_c) state_nx_c = EXT_BRK;
                    else begin
                        emit_c     = 1'b1;
                        emit_rel_c = 1'b1;
                    end
                end
                EXT_BRK: begin
                    if (is_ext_c || is_brk_c) state_nx_c = EXT_BRK;
                    else begin
                        emit_c     = 1'b1;
                        emit_ext_c = 1'b1;
                        emit_rel_c = 1'b1;
                    end
                end
            endcase
        end
    end

    // Synchronizer, FSM, prefix timeout and registered outputs.
    always_ff @(posedge CLK or negedge Resetn) begin
        if (!Resetn) begin
            s1          <= 1'b0;
            s2          <= 1'b0;
            s3          <= 1'b0;
            state       <= IDLE;
            cnt         <= '0;
            KeyValid    <= 1'b0;
            KeyCode     <= 8'h00;
            KeyExtended <= 1'b0;
            KeyRelease  <= 1'b0;
            LeftHeld    <= 1'b0;
            RightHeld   <= 1'b0;
            FireHeld    <= 1'b0;
            ParityErr   <= 1'b0;
        end else begin
            s1        <= RxReady;
            s2        <= s1;
            s3        <= s2;
            KeyValid  <= 1'b0;
            ParityErr <= 1'b0;

            if (stb_c) begin
                // A strobe coinciding with expiry is still decoded in the current state.
                cnt <= '0;
                if (!par_ok_c) begin
                    ParityErr <= 1'b1;
                    state     <= IDLE;
                end else begin
                    state <= state_nx_c;
                    if (emit_c) begin
                        KeyValid    <= 1'b1;
                        KeyCode     <= RxData;
                        KeyExtended <= emit_ext_c;
                        KeyRelease  <= emit_rel_c;
                        if (emit_ext_c && (RxData == CODE_LEFT))
                            LeftHeld <= ~emit_rel_c;
                        if (emit_ext_c && (RxData == CODE_RIGHT))
                            RightHeld <= ~emit_rel_c;
                        if (!emit_ext_c && (RxData == CODE_FIRE))
                            FireHeld <= ~emit_rel_c;
                    end
                end
            end else if (state != IDLE) begin
                if (cnt >= CNT_W'(TIMEOUT)) begin
                    state <= IDLE;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: doc/ps2_scancode_decoder.md
# ps2_scancode_decoder

Consumes completed frames from the PS/2 serial receiver, which runs on the keyboard's clock, and turns them into key events in the system clock domain. It synchronizes the receiver's frame-ready level, checks odd parity, and strips the 0xE0 (extended) and 0xF0 (break) prefixes. It outputs a one-cycle key event plus held-state levels for the three game controls: left arrow, right arrow and space. It sits between the PS/2 receiver and the game controller logic.

## Interface
- TIMEOUT, 100000: system clocks a pending prefix may wait for its next byte before it is discarded (≥2).
- CLK  in  1  system clock; all logic on rising edge.
- Resetn  in  1  reset, asynchronous, active-low.
- RxReady  in  1  receiver frame-complete level (PS/2 clock domain); high ≥1 PS/2 clock period; RxData/RxParity stable while high.
- RxData  in  8  received byte, LSB-first order already resolved.
- RxParity  in  1  received parity bit.
- KeyValid  out  1  one-cycle strobe: a complete key event.
- KeyCode  out  8  final scan code of the event; held until the next event.
- KeyExtended  out  1  event was preceded by 0xE0; held with KeyCode.
- KeyRelease  out  1  event was a break (0xF0 seen); held with KeyCode.
- LeftHeld  out  1  level: E0 6B is pressed.
- RightHeld  out  1  level: E0 74 is pressed.
- FireHeld  out  1  level: 29 (space, non-extended) is pressed.
- ParityErr  out  1  one-cycle strobe: byte failed odd parity.

## Operation
- Synchronizer: RxReady → s1 → s2 → s3 flops; byte strobe stb = s2 & ~s3. RxData and RxParity are sampled directly on stb; they are stable for the entire RxReady high time.
- Parity: a byte is good when ^{RxData,RxParity}==1. On a bad byte: ParityErr pulses, no KeyValid, FSM → IDLE, held levels unchanged.
- Ignored codes (0x00, 0xAA, 0xEE, 0xFA, 0xFC, 0xFF) produce no event. In IDLE they are dropped. In any prefix state they return the FSM to IDLE.
- FSM states and transitions on a good stb:
  - IDLE: E0→EXT; F0→BRK; other→emit(make, non-ext).
  - EXT: E0→EXT; F0→EXT_BRK; other→emit(make, ext), →IDLE.
  - BRK: F0→BRK; E0→EXT_BRK; other→emit(break, non-ext), →IDLE.
  - EXT_BRK: E0/F0→EXT_BRK; other→emit(break, ext), →IDLE.
- emit: register KeyCode, KeyExtended and KeyRelease, and pulse KeyValid.
- Held levels update in the same cycle as emit:
  - LeftHeld: set on make ext 6B, cleared on break ext 6B.
  - RightHeld: same rule with ext 74.
  - FireHeld: same rule with non-ext 29.
  - Extended 29 and non-extended 6B/74 do not affect the held levels.
- Timeout: a counter runs while state≠IDLE and reloads on every stb. When it reaches TIMEOUT, FSM → IDLE and no event is emitted.
- Reset (asynchronous, any time): state IDLE; synchronizer flops 0; all outputs 0 (KeyValid, KeyCode=8'h00, KeyExtended, KeyRelease, all Held levels, ParityErr); timeout counter 0.

## Timing
- RxReady first sampled high at edge N. Then s2=1 after edge N+1, and KeyValid/ParityErr are high for exactly the cycle following edge N+2. Latency is 3 edges.
- One strobe per RxReady high period, however long it stays high. A new frame requires RxReady to go low and be sampled low at least twice.
- KeyValid and ParityErr are never high together.
- Held levels change on the same edge that KeyValid rises.
- A stb arriving in the same cycle as the timeout expiry is processed in the current state; the stb wins.

## Test plan
- Press/release space: frames 29, F0, 29 → KeyValid twice. First event KeyCode=29/Rel=0 with FireHeld=1; second KeyCode=29/Rel=1 with FireHeld=0. Each KeyValid comes 3 edges after its RxReady.
- Extended arrows: E0 6B, E0 74, E0 F0 6B → LeftHeld 1→0, RightHeld remains 1. Three events, all Ext=1.
- Parity error: byte 29 with RxParity=1 (even parity) → ParityErr pulse, no KeyValid, FireHeld unchanged. A following good E0 6B decodes normally.
- Prefix timeout: E0, then idle for TIMEOUT+2 cycles, then 29 → event KeyCode=29 with Ext=0 and FireHeld=1.
- Noise codes: AA in IDLE gives no event. F0, FA, 29 → FA aborts BRK, so 29 is emitted as a make (FireHeld=1).
- Async reset asserted mid-sequence after E0 F0 with LeftHeld=1 → all outputs 0 immediately. After release, a single 6B decodes as a non-extended make.
